// File: rtl/riscv_exu_issue.sv
`default_nettype none
// ============================================================================
// Module   : riscv_exu_issue (with package riscv_exu_issue_pkg)
// Purpose  : In-order issue scheduler between decode (IDU) and the execute
//            control unit (EXU). Buffers decoded instructions in a DEPTH-entry
//            FIFO, tracks pending destination registers in a 32-bit
//            scoreboard, issues one instruction at a time once no RAW/WAW
//            hazard remains, and drops all queued work on a branch flush.
// Ports    : clock, reset_n           - clock / async active-low reset
//            idu_vld, idu_rdy, idu    - decoded instruction handshake
//            exu_vld, exu_idu         - one-cycle issue pulse + held payload
//            exu_done                 - EXU finished in-flight instruction
//            register_write_en/_write - EXU writeback strobe and index
//            flush                    - EXU redirect, kills queued work
//            busy                     - scoreboard, bit n = xn write pending
//            empty                    - nothing queued and nothing in flight
//            stall_cycles             - saturating hazard-stall counter
// Revision : 1.0 - initial release
// ============================================================================
package riscv_exu_issue_pkg;
   typedef struct packed {
      logic [7:0] seq;
      logic [6:0] op;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [4:0] rd;
   } idu_t;
endpackage

module riscv_exu_issue
   import riscv_exu_issue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             idu_vld,
   output logic             idu_rdy,
   input  idu_t             idu,
   output logic             exu_vld,
   output idu_t             exu_idu,
   input  logic             exu_done,
   input  logic             register_write_en,
   input  logic [4:0]       register_write,
   input  logic             flush,
   output logic [31:0]      busy,
   output logic             empty,
   output logic [CNT_W-1:0] stall_cycles
);
   localparam int c_AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

   idu_t             r_fifo [DEPTH];
   logic [c_AW:0]    r_wptr;
   logic [c_AW:0]    r_rptr;
   logic             r_live;
   logic             r_in_flight;
   logic             r_exu_vld;
   idu_t             r_exu_idu;
   logic [31:0]      r_busy;
   logic [CNT_W-1:0] r_stall;

   logic             w_full;
   logic             w_nempty;
   logic             w_push;
   idu_t             w_head;
   logic [31:0]      w_wb_mask;
   logic [31:0]      w_done_mask;
   logic [31:0]      w_set_mask;
   logic [31:0]      w_busy_eff;
   logic             w_can;
   logic             w_hz;
   logic             w_issue;

   // Extra pointer MSB distinguishes full from empty once the index wraps.
   assign w_full   = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
   assign w_nempty = (r_wptr != r_rptr);
   assign w_head   = r_fifo[r_rptr[c_AW-1:0]];

   // r_live keeps idu_rdy low until the first edge after reset release.
   assign idu_rdy  = r_live & ~w_full & ~flush;
   assign w_push   = idu_vld & idu_rdy;

   // Writeback in the current cycle is visible to the hazard check (bypass);
   // x0 can never be pending.
   assign w_wb_mask   = register_write_en ? (32'd1 << register_write) : 32'd0;
   assign w_busy_eff  = r_busy & ~w_wb_mask & ~32'd1;
   assign w_done_mask = (exu_done & r_in_flight) ? (32'd1 << r_exu_idu.rd) : 32'd0;

   assign w_can   = w_nempty & (~r_in_flight | exu_done) & ~flush;
   assign w_hz    = w_busy_eff[w_head.rs1] | w_busy_eff[w_head.rs2] |
                    w_busy_eff[w_head.rd];
   assign w_issue = w_can & ~w_hz;

   assign w_set_mask = (w_issue && (w_head.rd != 5'd0)) ? (32'd1 << w_head.rd) : 32'd0;

   // FIFO storage carries no reset; validity is defined by the pointers.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_fifo[r_wptr[c_AW-1:0]] <= idu;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_live      <= 1'b0;
         r_in_flight <= 1'b0;
         r_exu_vld   <= 1'b0;
         r_exu_idu   <= '0;
         r_busy      <= '0;
         r_stall     <= '0;
      end else begin
         r_live    <= 1'b1;
         r_exu_vld <= w_issue;

         if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_push)  r_wptr <= r_wptr + 1'b1;
            if (w_issue) r_rptr <= r_rptr + 1'b1;
         end

         // A flush arrives together with exu_done of the flushing op.
         if (flush)         r_in_flight <= 1'b0;
         else if (w_issue)  r_in_flight <= 1'b1;
         else if (exu_done) r_in_flight <= 1'b0;

         if (w_issue) r_exu_idu <= w_head;

         // Set after clear: a new issue to the same rd keeps the bit pending.
         r_busy <= (r_busy & ~w_wb_mask & ~w_done_mask) | w_set_mask;

         if (w_can && w_hz && (r_stall != c_CNT_MAX)) begin
            r_stall <= r_stall + 1'b1;
         end
      end
   end

   assign exu_vld      = r_exu_vld;
   assign exu_idu      = r_exu_idu;
   assign busy         = r_busy;
   assign empty        = ~w_nempty & ~r_in_flight;
   assign stall_cycles = r_stall;

endmodule
`default_nettype wire
